// File: rtl/rc4_stream_xor.sv
// RC4 keystream consumer: buffers keystream bytes and XORs them onto host data,
// one byte per handshake, with an optional drop-N discard after each start.
module rc4_stream_xor #(
  parameter int unsigned KS_DEPTH = 8,
  parameter int unsigned DROP_N   = 0,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          msg_len,
  input  logic                      ks_valid,
  input  logic [7:0]                ks_data,
  output logic                      ks_ready,
  input  logic                      din_valid,
  input  logic [7:0]                din_data,
  output logic                      din_ready,
  output logic                      dout_valid,
  output logic [7:0]                dout_data,
  input  logic                      dout_ready,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(KS_DEPTH):0] ks_level
);

  localparam int unsigned AW     = $clog2(KS_DEPTH);
  localparam int unsigned LVL_W  = AW + 1;
  localparam int unsigned DROP_W = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(KS_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DROP = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [LEN_W-1:0]    rem_in_q;
  logic [LEN_W-1:0]    rem_ks_q;
  logic [DROP_W-1:0]   drop_cnt_q;
  logic [7:0]          ks_mem [KS_DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [LVL_W-1:0]    level_q;

  logic start_ok;
  logic ks_fire;
  logic ks_push;
  logic drop_fire;
  logic din_fire;
  logic dout_fire;

  assign start_ok  = start && (state_q == S_IDLE);
  assign ks_fire   = ks_valid && ks_ready;
  assign ks_push   = ks_fire && (state_q == S_RUN);
  assign drop_fire = ks_fire && (state_q == S_DROP);
  assign din_fire  = din_valid && din_ready;
  assign dout_fire = dout_valid && dout_ready;
  assign ks_level  = level_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (DROP_N > 0) begin
            state_d = S_DROP;
          end else if (msg_len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DROP: begin
        if (drop_fire && (drop_cnt_q == DROP_W'(1))) begin
          state_d = (rem_in_q == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        // Last byte already accepted; leave once it has been handed downstream.
        if ((rem_in_q == '0) && dout_fire) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    ks_ready  = 1'b0;
    din_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_DROP: begin
        busy     = 1'b1;
        ks_ready = 1'b1;
      end
      S_RUN: begin
        busy      = 1'b1;
        ks_ready  = (level_q < LVL_FULL) && (rem_ks_q != '0);
        din_ready = (level_q != '0) && (rem_in_q != '0) && (!dout_valid || dout_ready);
      end
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Message counters and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_in_q   <= '0;
      rem_ks_q   <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else if (start_ok) begin
      rem_in_q   <= msg_len;
      rem_ks_q   <= msg_len;
      drop_cnt_q <= DROP_W'(DROP_N);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      if (drop_fire) begin
        drop_cnt_q <= drop_cnt_q - DROP_W'(1);
      end
      if (ks_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        rem_ks_q <= rem_ks_q - LEN_W'(1);
      end
      if (din_fire) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rem_in_q <= rem_in_q - LEN_W'(1);
      end
      case ({ks_push, din_fire})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Keystream storage; contents are don't-care once pointers are cleared
  always_ff @(posedge clk) begin
    if (ks_push) begin
      ks_mem[wr_ptr_q] <= ks_data;
    end
  end

  // Output byte register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_data  <= 8'h00;
    end else if (din_fire) begin
      dout_valid <= 1'b1;
      dout_data  <= din_data ^ ks_mem[rd_ptr_q];
    end else if (dout_fire) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Scoreboard bench for rc4_stream_xor: one instance without drop, one with DROP_N=2,
// selected by sel; a monitor pops expected bytes on every output transfer.
module tb_rc4_stream_xor;

  localparam int unsigned KS_DEPTH = 8;
  localparam int unsigned LEN_W    = 16;
  localparam int unsigned LVL_W    = $clog2(KS_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sel;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             ks_valid;
  logic [7:0]       ks_data;
  logic             din_valid;
  logic [7:0]       din_data;
  logic             dout_ready;

  logic             ks_ready0, din_ready0, dout_valid0, busy0, done0;
  logic [7:0]       dout_data0;
  logic [LVL_W-1:0] ks_level0;
  logic             ks_ready2, din_ready2, dout_valid2, busy2, done2;
  logic [7:0]       dout_data2;
  logic [LVL_W-1:0] ks_level2;

  logic             ks_ready, din_ready, dout_valid, busy, done;
  logic [7:0]       dout_data;
  logic [LVL_W-1:0] ks_level;

  assign ks_ready   = sel ? ks_ready2   : ks_ready0;
  assign din_ready  = sel ? din_ready2  : din_ready0;
  assign dout_valid = sel ? dout_valid2 : dout_valid0;
  assign dout_data  = sel ? dout_data2  : dout_data0;
  assign busy       = sel ? busy2       : busy0;
  assign done       = sel ? done2       : done0;
  assign ks_level   = sel ? ks_level2   : ks_level0;

  rc4_stream_xor #(.KS_DEPTH(KS_DEPTH), .DROP_N(0), .LEN_W(LEN_W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .msg_len(msg_len),
    .ks_valid(ks_valid && !sel), .ks_data(ks_data), .ks_ready(ks_ready0),
    .din_valid(din_valid && !sel), .din_data(din_data), .din_ready(din_ready0),
    .dout_valid(dout_valid0), .dout_data(dout_data0), .dout_ready(dout_ready && !sel),
    .busy(busy0), .done(done0), .ks_level(ks_level0)
  );

  rc4_stream_xor #(.KS_DEPTH(KS_DEPTH), .DROP_N(2), .LEN_W(LEN_W)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .msg_len(msg_len),
    .ks_valid(ks_valid && sel), .ks_data(ks_data), .ks_ready(ks_ready2),
    .din_valid(din_valid && sel), .din_data(din_data), .din_ready(din_ready2),
    .dout_valid(dout_valid2), .dout_data(dout_data2), .dout_ready(dout_ready && sel),
    .busy(busy2), .done(done2), .ks_level(ks_level2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_q  [$];
  logic [7:0] ks_vec [$];
  logic [7:0] din_vec[$];
  logic [7:0] exp_b;

  int n_ks, n_din, n_dout, done_cnt, done_c, first_of, last_of, busy_cnt, max_lvl, stall_cyc;
  bit full_bad, empty_bad, stall_bad, extra_ks_bad, drop_bad;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted output byte must match the queue head
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check("dout_unexpected", int'(dout_data), -1);
      end else begin
        exp_b = exp_q.pop_front();
        check("dout_data", int'(dout_data), int'(exp_b));
      end
    end
  end

  task automatic run_msg(input int len, input int drop, input int stall,
                         input int restart_c, input int abort_n, input int budget);
    int   ki, di, abort_c;
    logic kf, df, of, live, prev_stall;
    logic [7:0] prev_data;
    bit   aborted;
    ki = 0; di = 0; abort_c = -1; aborted = 0; prev_stall = 0; prev_data = 8'h00;
    n_ks = 0; n_din = 0; n_dout = 0; done_cnt = 0; done_c = -1; first_of = -1; last_of = -1;
    busy_cnt = 0; max_lvl = 0; stall_cyc = 0;
    full_bad = 0; empty_bad = 0; stall_bad = 0; extra_ks_bad = 0; drop_bad = 0;
    start      = 1'b1;
    msg_len    = LEN_W'(len);
    ks_valid   = (ks_vec.size() > 0);
    ks_data    = ks_valid ? ks_vec[0] : 8'h00;
    din_valid  = (din_vec.size() > 0);
    din_data   = din_valid ? din_vec[0] : 8'h00;
    dout_ready = (stall == 0);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      kf   = ks_valid && ks_ready;
      df   = din_valid && din_ready;
      of   = dout_valid && dout_ready;
      live = rst_n;
      if (live) begin
        if (kf && (n_ks < drop) && (din_ready || ks_level != '0)) drop_bad = 1;
        if (ks_ready && (n_ks >= len + drop)) extra_ks_bad = 1;
        if ((ks_level == LVL_W'(KS_DEPTH)) && ks_ready) full_bad = 1;
        if ((ks_level == '0) && din_ready) empty_bad = 1;
        if (prev_stall && (!dout_valid || dout_data != prev_data)) stall_bad = 1;
        if (dout_valid && !dout_ready && din_ready) stall_bad = 1;
        prev_stall = dout_valid && !dout_ready;
        prev_data  = dout_data;
        if (prev_stall) stall_cyc++;
        if (kf) n_ks++;
        if (df) n_din++;
        if (of) begin
          n_dout++;
          if (first_of < 0) first_of = c;
          last_of = c;
        end
        if (done) begin
          done_cnt++;
          done_c = c;
        end
        if (busy) busy_cnt++;
        if (int'(ks_level) > max_lvl) max_lvl = int'(ks_level);
      end else begin
        prev_stall = 0;
      end
      if (aborted && c == abort_c + 2)
        check("reset_outputs_zero",
              int'({ks_ready, din_ready, dout_valid, dout_data, busy, done, ks_level}), 0);
      @(posedge clk);
      #1;
      start = (c + 1 == restart_c);
      if (start) msg_len = LEN_W'(5);
      if (kf && live) ki++;
      if (df && live) di++;
      ks_valid   = (ki < ks_vec.size());
      ks_data    = ks_valid ? ks_vec[ki] : 8'h00;
      din_valid  = (di < din_vec.size());
      din_data   = din_valid ? din_vec[di] : 8'h00;
      dout_ready = (c + 1 >= stall);
      if (abort_n > 0 && !aborted && n_dout == abort_n) begin
        rst_n   = 1'b0;
        aborted = 1;
        abort_c = c;
      end else if (aborted && c == abort_c + 1) begin
        rst_n = 1'b1;
        exp_q.delete();
      end
      if (done_cnt > 0 && c >= done_c + 2) break;
      if (aborted && c >= abort_c + 4) break;
    end
    start = 1'b0; ks_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ks_vec[i] ^ din_vec[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; msg_len = '0;
    ks_valid = 1'b0; ks_data = 8'h00; din_valid = 1'b0; din_data = 8'h00; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_d0", int'({ks_ready, din_ready, dout_valid, dout_data, busy, done, ks_level}), 0);
    sel = 1'b1;
    #1;
    check("reset_state_d2", int'({ks_ready, din_ready, dout_valid, dout_data, busy, done, ks_level}), 0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vector: "Plaintext" under keystream EB 9F 77 ...
    ks_vec  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    din_vec = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    exp_q   = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    run_msg(9, 0, 0, 0, 0, 60);
    check("kv_dout_count", n_dout, 9);
    check("kv_ks_count", n_ks, 9);
    check("kv_done_count", done_cnt, 1);
    check("kv_done_after_last", done_c, last_of + 1);
    check("kv_sb_empty", exp_q.size(), 0);

    // Drop-2 on the second instance
    sel = 1'b1;
    ks_vec  = '{8'h11, 8'h22, 8'h33, 8'h44};
    din_vec = '{8'h00, 8'h00};
    exp_q   = '{8'h33, 8'h44};
    run_msg(2, 2, 0, 0, 0, 40);
    check("drop_ks_count", n_ks, 4);
    check("drop_discard_clean", int'(drop_bad), 0);
    check("drop_level_le2", int'(max_lvl <= 2), 1);
    check("drop_dout_count", n_dout, 2);
    check("drop_done_count", done_cnt, 1);
    sel = 1'b0;
    @(posedge clk); #1;

    // Backpressure: 12 cycles of dout_ready low with keystream always offered
    ks_vec.delete(); din_vec.delete();
    for (int i = 0; i < 20; i++) begin
      ks_vec.push_back(8'(8'h3C + i * 29));
      din_vec.push_back(8'(i * 11 + 1));
    end
    load(20);
    run_msg(20, 0, 12, 0, 0, 120);
    check("bp_level_saturates", max_lvl, 8);
    check("bp_full_blocks_ks", int'(full_bad), 0);
    check("bp_output_stable", int'(stall_bad), 0);
    check("bp_stall_cycles", stall_cyc, 9);
    check("bp_empty_blocks_din", int'(empty_bad), 0);
    check("bp_stream_rate", last_of - first_of, 19);
    check("bp_dout_count", n_dout, 20);
    check("bp_done_count", done_cnt, 1);

    // Zero length
    ks_vec  = '{8'h01, 8'h02};
    din_vec = '{8'h03, 8'h04};
    run_msg(0, 0, 0, 0, 0, 20);
    check("zero_done_cycle", done_c, 1);
    check("zero_busy_cycles", busy_cnt, 1);
    check("zero_ks_count", n_ks, 0);
    check("zero_din_count", n_din, 0);
    check("zero_done_count", done_cnt, 1);

    // Prefetch limit with a start pulse while busy
    ks_vec  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    din_vec = '{8'h10, 8'h20, 8'h30};
    exp_q   = '{8'hB1, 8'h82, 8'h93};
    run_msg(3, 0, 0, 2, 0, 40);
    check("pf_ks_count", n_ks, 3);
    check("pf_no_extra_ks_ready", int'(extra_ks_bad), 0);
    check("pf_dout_count", n_dout, 3);
    check("pf_done_count", done_cnt, 1);
    check("pf_idle_after", int'(busy), 0);

    // Reset after 4 of 10 bytes, then a 1-byte message
    ks_vec.delete(); din_vec.delete();
    for (int i = 0; i < 10; i++) begin
      ks_vec.push_back(8'(8'hC0 + i));
      din_vec.push_back(8'(8'h05 * i));
    end
    load(10);
    run_msg(10, 0, 0, 0, 4, 60);
    check("abort_dout_count", n_dout, 4);
    check("abort_no_done", done_cnt, 0);
    ks_vec  = '{8'h5A};
    din_vec = '{8'hA5};
    exp_q   = '{8'hFF};
    run_msg(1, 0, 0, 0, 0, 20);
    check("post_abort_dout_count", n_dout, 1);
    check("post_abort_done_count", done_cnt, 1);
    check("post_abort_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
Consumer end of the RC4 keystream interface. It accepts keystream bytes from the RC4 generator and data bytes from the host, and emits data XOR keystream, one byte per handshake. Keystream bytes are buffered in a small FIFO. Optional RC4-drop[n] discard applies after each start. Encrypt and decrypt are the same operation.

Parameters:
KS_DEPTH, 8, keystream FIFO depth in bytes; must be a power of 2 and at least 2.
DROP_N, 0, keystream bytes discarded after each start, before any XOR.
LEN_W, 16, width of the message length field.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  single-cycle pulse that begins a message; honoured only in IDLE.
msg_len  in  LEN_W  message length in bytes; latched on start.
ks_valid  in  1  keystream byte available.
ks_data  in  8  keystream byte.
ks_ready  out  1  block accepts a keystream byte.
din_valid  in  1  plaintext/ciphertext byte available.
din_data  in  8  input data byte.
din_ready  out  1  block accepts a data byte.
dout_valid  out  1  output byte valid.
dout_data  out  8  din_data XOR keystream.
dout_ready  in  1  downstream accepts the output byte.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when the message is complete.
ks_level  out  clog2(KS_DEPTH)+1  current keystream FIFO occupancy.

Behaviour:
- Reset is synchronous to clk with rst_n active low. On reset: state=IDLE; FIFO pointers, level and all counters = 0; ks_ready=0, din_ready=0, dout_valid=0, dout_data=0, busy=0, done=0, ks_level=0.
- Reset asserted mid-message aborts the message immediately. There is no done pulse, and buffered keystream is discarded.
- Handshakes: a transfer occurs when valid and ready are both high on a rising edge. Once dout_valid is high, dout_valid and dout_data stay stable until dout_ready is high.
- States are IDLE, DROP, RUN and FIN.
- IDLE:
  - ks_ready=0 and din_ready=0.
  - On start: latch msg_len into rem_in (bytes still to accept) and rem_ks (keystream bytes still to fetch); clear the FIFO.
  - Next state is DROP if DROP_N>0; otherwise FIN if msg_len==0; otherwise RUN.
  - start is ignored in every other state.
- DROP:
  - ks_ready=1. Each keystream transfer decrements drop_cnt, which starts at DROP_N; the byte is not stored.
  - On the transfer that brings drop_cnt to 0, go to RUN, or to FIN if msg_len==0.
- RUN:
  - Keystream side: ks_ready = (level<KS_DEPTH) && (rem_ks!=0). Each accepted byte is pushed to the FIFO and decrements rem_ks. The block never fetches keystream beyond msg_len.
  - Data side: din_ready = (level!=0) && (rem_in!=0) && (!dout_valid || dout_ready).
  - On a din transfer: dout_data <= din_data ^ FIFO head; dout_valid <= 1; the FIFO pops; rem_in decrements.
  - Latency is 1 cycle from din transfer to dout_valid. Sustained throughput is 1 byte per cycle.
  - A push and a pop in the same cycle leave level unchanged. When level==KS_DEPTH, ks_ready=0. When level==0, din_ready=0.
  - A dout transfer with no new din transfer in the same cycle clears dout_valid.
  - When rem_in==0 and the final byte completes its dout transfer, go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE. busy=0 starting the cycle after FIN.
- Width rules: rem_in and rem_ks are LEN_W bits, and both are 0 at message end. There is no wrap-around. Maximum message length is 2^LEN_W-1 bytes.

Test Plan:
- Known vector, DROP_N=0, msg_len=9.
  - Stimulus: keystream EB 9F 77 81 B7 34 CA 72 A7; din "Plaintext" = 50 6C 61 69 6E 74 65 78 74.
  - Required: dout = BB F3 16 E8 D9 40 AF 0A D3; done pulses 1 cycle after the 9th dout transfer.
- Drop, DROP_N=2, msg_len=2.
  - Stimulus: keystream 11 22 33 44; din 00 00.
  - Required: dout = 33 44; 11 and 22 are accepted while din_ready=0; ks_level never exceeds 2.
- Backpressure, KS_DEPTH=8, msg_len=20, ks_valid held high.
  - Stimulus: dout_ready held 0 for 12 cycles.
  - Required: dout_data stays stable; din_ready=0; ks_level saturates at 8 with ks_ready=0. After release, the remaining bytes stream at 1 byte per cycle.
- Zero length, DROP_N=0, msg_len=0.
  - Required: done is high in the cycle after start; no ks or din transfer occurs; busy is high for 1 cycle.
- Prefetch limit, msg_len=3, ks_valid held high.
  - Required: exactly 3 keystream transfers occur; ks_ready stays 0 thereafter; a start pulse while busy is ignored.
- Reset mid-RUN after 4 of 10 bytes.
  - Required: all outputs read 0 on the cycle after reset; no done pulse. A new message with msg_len=1 then completes correctly.
